// File: rtl/steer_pkg.sv
// rtl/steer_pkg.sv - shared verdict/state types and verdict helpers for motor_steer
// Contents: operate_t (detector verdict codes), steer_state_t (steering FSM states),
//           mode_legal() (verdict is one of the four defined codes),
//           mode_target() (state a confirmed verdict steers towards).
package steer_pkg;

   typedef enum logic [2:0] {
      OP_NO_COLOR = 3'b000,
      OP_RIGHT    = 3'b001,
      OP_MIDDLE   = 3'b010,
      OP_LEFT     = 3'b100
   } operate_t;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SCAN       = 3'd1,
      ST_FORWARD    = 3'd2,
      ST_TURN_LEFT  = 3'd3,
      ST_TURN_RIGHT = 3'd4
   } steer_state_t;

   function automatic logic mode_legal(input logic [2:0] mode);
      case (mode)
         OP_NO_COLOR, OP_RIGHT, OP_MIDDLE, OP_LEFT: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

   function automatic steer_state_t mode_target(input logic [2:0] mode);
      case (mode)
         OP_LEFT:   return ST_TURN_LEFT;
         OP_MIDDLE: return ST_FORWARD;
         OP_RIGHT:  return ST_TURN_RIGHT;
         default:   return ST_SCAN;
      endcase
   endfunction

endpackage

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - single-wheel PWM generator with wrap-aligned duty/dir updates
// Ports: clk, reset (async active-low), duty (target high cycles per period),
//        dir_in (target direction), force_off (zero the duty at once),
//        pwm (registered PWM), dir (registered direction, 1 = forward).
module pwm_gen #(
   parameter  int PWM_PERIOD = 1000,
   localparam int DW         = $clog2(PWM_PERIOD + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [DW-1:0] duty,
   input  logic          dir_in,
   input  logic          force_off,
   output logic          pwm,
   output logic          dir
);

   logic [DW-1:0] cnt;
   logic [DW-1:0] cnt_next;
   logic [DW-1:0] active_duty;
   logic [DW-1:0] duty_next;
   logic          wrap;

   // Duty only changes at the period boundary so no pulse is clipped or
   // stretched; force_off is the one exception and drops the output at once.
   always_comb begin
      wrap      = (cnt == DW'(PWM_PERIOD - 1));
      cnt_next  = wrap ? '0 : cnt + 1'b1;
      duty_next = active_duty;
      if (force_off)
         duty_next = '0;
      else if (wrap)
         duty_next = duty;
   end

   // pwm is computed from the post-edge counter/duty so the registered output
   // always equals (cnt < active_duty) for the values currently held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         active_duty <= '0;
         pwm         <= 1'b0;
         dir         <= 1'b1;
      end else begin
         cnt         <= cnt_next;
         active_duty <= duty_next;
         pwm         <= (cnt_next < duty_next);
         if (wrap)
            dir <= dir_in;
      end
   end

endmodule

// File: rtl/motor_steer.sv
// rtl/motor_steer.sv - verdict debounce, scan/approach FSM and stream watchdog driving two PWM wheels
// Ports: clk, reset (async active-low), enable (run request), operate_mode (detector verdict),
//        frame_done (end-of-frame strobe), left_pwm/right_pwm, left_dir/right_dir (1 = forward),
//        state (current FSM state), lost (stream watchdog expired).
module motor_steer
   import steer_pkg::*;
#(
   parameter int PWM_PERIOD     = 1000,
   parameter int DUTY_FWD       = 700,
   parameter int DUTY_TURN      = 500,
   parameter int DUTY_SCAN      = 350,
   parameter int CONFIRM_FRAMES = 3,
   parameter int LOST_TIMEOUT   = 2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [2:0] operate_mode,
   input  logic       frame_done,
   output logic       left_pwm,
   output logic       right_pwm,
   output logic       left_dir,
   output logic       right_dir,
   output logic [2:0] state,
   output logic       lost
);

   localparam int DW = $clog2(PWM_PERIOD + 1);
   localparam int CW = $clog2(CONFIRM_FRAMES + 1);
   localparam int WW = $clog2(LOST_TIMEOUT + 1);

   steer_state_t  cur;
   logic [2:0]    candidate;
   logic [CW-1:0] confirm_cnt;
   logic [CW-1:0] confirm_next;
   logic [WW-1:0] wd_cnt;
   logic          expire;
   logic          force_off;
   logic [DW-1:0] left_duty_tgt;
   logic [DW-1:0] right_duty_tgt;
   logic          left_dir_tgt;
   logic          right_dir_tgt;

   assign state = cur;

   // A frame_done on the expiry cycle wins, so expiry requires no strobe.
   assign expire = !frame_done && !lost && (wd_cnt == WW'(LOST_TIMEOUT - 1));

   // Any path into IDLE (or sitting in it) zeroes both wheels without
   // waiting for the period wrap.
   assign force_off = !enable || expire || (cur == ST_IDLE);

   always_comb begin
      if (operate_mode != candidate)
         confirm_next = CW'(1);
      else if (confirm_cnt == CW'(CONFIRM_FRAMES))
         confirm_next = confirm_cnt;
      else
         confirm_next = confirm_cnt + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur         <= ST_IDLE;
         candidate   <= OP_NO_COLOR;
         confirm_cnt <= '0;
      end else if (!enable || expire) begin
         cur         <= ST_IDLE;
         candidate   <= OP_NO_COLOR;
         confirm_cnt <= '0;
      end else if (cur == ST_IDLE) begin
         // Leaving IDLE always restarts confirmation from scratch.
         if (!lost) begin
            cur         <= ST_SCAN;
            candidate   <= OP_NO_COLOR;
            confirm_cnt <= '0;
         end
      end else if (frame_done && mode_legal(operate_mode)) begin
         candidate   <= operate_mode;
         confirm_cnt <= confirm_next;
         if (confirm_next == CW'(CONFIRM_FRAMES))
            cur <= mode_target(operate_mode);
      end
   end

   // Watchdog holds at its last count once expired; only a strobe re-arms it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt <= '0;
         lost   <= 1'b0;
      end else if (frame_done) begin
         wd_cnt <= '0;
         lost   <= 1'b0;
      end else if (expire) begin
         lost <= 1'b1;
      end else if (!lost) begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   always_comb begin
      left_duty_tgt  = '0;
      right_duty_tgt = '0;
      left_dir_tgt   = 1'b1;
      right_dir_tgt  = 1'b1;
      case (cur)
         ST_SCAN: begin
            left_duty_tgt  = DW'(DUTY_SCAN);
            right_duty_tgt = DW'(DUTY_SCAN);
            right_dir_tgt  = 1'b0;
         end
         ST_FORWARD: begin
            left_duty_tgt  = DW'(DUTY_FWD);
            right_duty_tgt = DW'(DUTY_FWD);
         end
         ST_TURN_LEFT:  right_duty_tgt = DW'(DUTY_TURN);
         ST_TURN_RIGHT: left_duty_tgt  = DW'(DUTY_TURN);
         default: ;
      endcase
   end

   pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_left_pwm (
      .clk       (clk),
      .reset     (reset),
      .duty      (left_duty_tgt),
      .dir_in    (left_dir_tgt),
      .force_off (force_off),
      .pwm       (left_pwm),
      .dir       (left_dir)
   );

   pwm_gen #(.PWM_PERIOD(PWM_PERIOD)) u_right_pwm (
      .clk       (clk),
      .reset     (reset),
      .duty      (right_duty_tgt),
      .dir_in    (right_dir_tgt),
      .force_off (force_off),
      .pwm       (right_pwm),
      .dir       (right_dir)
   );

endmodule

// File: doc/motor_steer.md
# motor_steer

Closed-loop steering controller that consumes the per-frame `operate_mode` verdict produced by the colour-detection stage and drives the two drive motors. It debounces verdicts across frames, runs a scan/approach state machine, watches for a stalled camera stream, and generates glitch-free PWM and direction signals for the left and right motor drivers. It sits between the camera detection path and the H-bridge pins in the integration top level.

## Interface
Parameters:
- `PWM_PERIOD`, 1000: PWM period in `clk` cycles, at least 2.
- `DUTY_FWD`, 700: high cycles per period when driving forward.
- `DUTY_TURN`, 500: high cycles per period for the outer wheel while turning.
- `DUTY_SCAN`, 350: high cycles per period for both wheels while scanning.
- `CONFIRM_FRAMES`, 3: consecutive identical verdicts required before a state change, at least 1.
- `LOST_TIMEOUT`, 2_000_000: `clk` cycles without `frame_done` before the motors stop.

Ports:
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: run request. Low forces IDLE.
- `operate_mode`, in, 3: detector verdict. LEFT=100, MIDDLE=010, RIGHT=001, NO_COLOR=000.
- `frame_done`, in, 1: one-cycle strobe at end of frame (row 239, col 319). `operate_mode` is valid on this cycle.
- `left_pwm`, out, 1: left motor PWM, registered.
- `right_pwm`, out, 1: right motor PWM, registered.
- `left_dir`, out, 1: left direction, 1 = forward.
- `right_dir`, out, 1: right direction, 1 = forward.
- `state`, out, 3: current FSM state, for debug/LEDs.
- `lost`, out, 1: high while the stream watchdog has expired.

## Operation
- States: IDLE, SCAN, FORWARD, TURN_LEFT, TURN_RIGHT.
- Drive per state:
  - IDLE: both duties 0, both dirs 1.
  - SCAN: left forward, right reverse, both `DUTY_SCAN`.
  - FORWARD: both forward at `DUTY_FWD`.
  - TURN_LEFT: right at `DUTY_TURN`, left at 0, both dirs forward.
  - TURN_RIGHT: the mirror of TURN_LEFT.
- Debounce:
  - On each `frame_done` with a legal code, compare against the `candidate` register.
  - If equal, increment `confirm_cnt`, saturating at `CONFIRM_FRAMES`. Otherwise load `candidate` and set `confirm_cnt` to 1.
  - When `confirm_cnt` reaches `CONFIRM_FRAMES`, the FSM moves to the mapped state: NO_COLOR→SCAN, MIDDLE→FORWARD, LEFT→TURN_LEFT, RIGHT→TURN_RIGHT.
  - An already-current target causes no change.
- Illegal codes (any other 3-bit value) on `frame_done` are ignored. `candidate` and `confirm_cnt` are unchanged.
- IDLE with `enable`=1 and `lost`=0 moves to SCAN on the next cycle, with the debounce counters cleared.
- Watchdog:
  - Counts cycles since the last `frame_done`.
  - On reaching `LOST_TIMEOUT`, set `lost`=1, go to IDLE, clear the debounce counters.
  - Any `frame_done` clears the watchdog and `lost`. The FSM then resumes via IDLE→SCAN and re-confirmation.
- `enable`=0: go to IDLE next cycle, clear the debounce counters, hold there.
- PWM generators:
  - Free-running counter 0..`PWM_PERIOD`-1. Output = (counter < active_duty).
  - `active_duty` and dir load from the FSM's target values only at counter wrap (counter = `PWM_PERIOD`-1).
  - Exception: entering IDLE zeroes the duty immediately.

## Timing
- Reset values: state IDLE, `candidate` NO_COLOR, `confirm_cnt` 0, watchdog 0, `lost` 0, PWM counters 0, `active_duty` 0, both pwm 0, both dir 1.
- Verdict latency: the state changes on the edge after the `CONFIRM_FRAMES`-th confirming `frame_done`, i.e. 1 cycle after that strobe.
- PWM latency: the new duty/dir appears at the first counter wrap after the state change, i.e. at most `PWM_PERIOD`+1 cycles later. A PWM pulse is never truncated or stretched except on entry to IDLE.
- Simultaneous events, priority: `reset` > `enable`=0 > `frame_done` > watchdog expiry.
  - A `frame_done` on the expiry cycle wins: no `lost`.
- Reset asserted mid-period clears everything asynchronously. Outputs go low with no clock.
- `frame_done` held high for multiple cycles counts once per cycle. The driver guarantees single-cycle strobes.

## Structure
- Package `steer_pkg` holds:
  - the `operate_t` enum (LEFT/RIGHT/MIDDLE/NO_COLOR encodings), shared with the detection stage;
  - the `steer_state_t` enum;
  - a `mode_legal()` function.
- Sub-module `pwm_gen` (parameter `PWM_PERIOD`; ports `clk`, `reset`, `duty`, `dir_in`, `force_off`, `pwm`, `dir`), instantiated once per wheel.
- `motor_steer` holds the FSM, debounce, and watchdog.

## Test plan
- Reset, `enable`=1, three `frame_done` with 010 → SCAN, then FORWARD 1 cycle after the third strobe. `left_pwm` high for 700 of each 1000 cycles starting at the next wrap.
- Verdicts 100, 100, 001, 001, 001 → never TURN_LEFT. TURN_RIGHT after the fifth strobe. `left_pwm` at 500 duty, `right_pwm` 0.
- Verdict 011 between two 010 strobes → ignored. FORWARD still reached after the third legal 010.
- No `frame_done` for 2_000_000 cycles while FORWARD → `lost`=1, IDLE, both pwm 0 immediately. One `frame_done` → `lost`=0, SCAN next cycle.
- `enable` dropped at PWM count 300 in FORWARD, with `frame_done` on the same cycle → IDLE next cycle, pwm 0, debounce cleared.
- `reset` low mid-pulse → all outputs at reset values with no clock edge. After release, IDLE.
